// File: rtl/bench_seq_bist_if.sv
// Controller and benchmark signal bundle for bench_seq_bist.
// master = controller/benchmark side, slave = the BIST harness.
interface bench_seq_bist_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 1
);
  logic             start;
  logic [15:0]      golden;
  logic [IN_W-1:0]  dut_in;
  logic             dut_rst_n;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      signature;

  modport master (
    output start, golden, dut_out,
    input  dut_in, dut_rst_n, busy, done,
    input  pass, signature
  );

  modport slave (
    input  start, golden, dut_out,
    output dut_in, dut_rst_n, busy, done,
    output pass, signature
  );
endinterface

// File: rtl/bench_seq_bist.sv
// LFSR pattern source + MISR compactor BIST for sequential benchmarks.
// Optional on-chip golden compare: define BENCH_BIST_GOLDEN_CMP_EN.
module bench_seq_bist #(
  parameter int          IN_W      = 12,
  parameter int          OUT_W     = 1,
  parameter int          PATTERNS  = 256,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic           clk,
  input logic           reset,
  bench_seq_bist_if.slave bus
);

  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] LAST = 16'(PATTERNS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_APPLY,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          state;
  logic [15:0]     cnt;
  logic [15:0]     lfsr;
  logic [15:0]     misr;
  logic [IN_W-1:0] din_q;
  logic            drst_q;
  logic            busy_q;
  logic            done_q;

  logic [15:0] lfsr_nxt;
  logic [15:0] misr_nxt;

  assign lfsr_nxt = {lfsr[14:0],
    lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign misr_nxt = {misr[14:0],
    misr[15] ^ misr[13] ^ misr[12] ^ misr[10]}
    ^ 16'(bus.dut_out);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      lfsr   <= SEED;
      misr   <= '0;
      din_q  <= '0;
      drst_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          drst_q <= 1'b1;
          din_q  <= '0;
          done_q <= 1'b0;
          if (bus.start) begin
            lfsr   <= SEED;
            misr   <= '0;
            cnt    <= '0;
            drst_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= S_RST;
          end
        end
        S_RST: begin
          cnt <= cnt + 16'd1;
          if (cnt == 16'd1) begin
            cnt    <= '0;
            drst_q <= 1'b1;
            din_q  <= lfsr[IN_W-1:0];
            state  <= S_APPLY;
          end
        end
        S_APPLY: begin
          lfsr <= lfsr_nxt;
          misr <= misr_nxt;
          cnt  <= cnt + 16'd1;
          if (cnt == LAST) begin
            din_q <= '0;
            state <= S_FLUSH;
          end else begin
            din_q <= lfsr_nxt[IN_W-1:0];
          end
        end
        S_FLUSH: begin
          // last response arrives one cycle after the last pattern
          misr   <= misr_nxt;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dut_in    = din_q;
  assign bus.dut_rst_n = drst_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.signature = misr;

`ifdef BENCH_BIST_GOLDEN_CMP_EN
  logic pass_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_q <= 1'b0;
    end else if (state == S_IDLE && bus.start) begin
      pass_q <= 1'b0;
    end else if (state == S_DONE) begin
      pass_q <= (misr == bus.golden);
    end
  end

  assign bus.pass = pass_q;
`else
  logic unused_golden;

  assign unused_golden = ^bus.golden;
  assign bus.pass      = 1'b0;
`endif

endmodule

// File: tb/tb_bench_seq_bist.sv
// Randomized self-checking bench for bench_seq_bist.
// Reference: LFSR/MISR polynomial arithmetic over recorded responses.
module tb_bench_seq_bist;

  localparam int          IN_W  = 12;
  localparam int          OUT_W = 3;
  localparam int          P     = 4;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [15:0] TAPS  = 16'hB400;

  logic clk = 1'b0;
  logic reset;

  bench_seq_bist_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  bench_seq_bist #(
    .IN_W(IN_W),
    .OUT_W(OUT_W),
    .PATTERNS(P),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [OUT_W-1:0] resp [P+1];
  logic [IN_W-1:0]  first_pat [2];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s,
                                       input logic [15:0] inj);
    return {s[14:0], ^(s & TAPS)} ^ inj;
  endfunction

  function automatic logic exp_pass(input logic [15:0] sig,
                                    input logic [15:0] gold);
`ifdef BENCH_BIST_GOLDEN_CMP_EN
    return sig == gold;
`else
    return 1'b0 & (sig == gold);
`endif
  endfunction

  task automatic run(input logic [15:0] gold_xor,
                     input int mid_start,
                     input bit hold);
    logic [15:0] lf;
    logic [15:0] sig;
    logic [15:0] gold;
    int busy_n;
    sig = '0;
    for (int i = 0; i <= P; i++) sig = step(sig, 16'(resp[i]));
    gold = sig ^ gold_xor;
    busy_n = 0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 0);
    bus.start = 1'b1;
    bus.dut_out = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.start = hold;
      check("rst_low", 32'(bus.dut_rst_n), 0);
      check("rst_din", 32'(bus.dut_in), 0);
      busy_n += int'(bus.busy);
    end
    lf = SEED;
    for (int k = 0; k < P; k++) begin
      @(negedge clk);
      check("pattern", 32'(bus.dut_in), 32'(lf[IN_W-1:0]));
      check("apply_rst_n", 32'(bus.dut_rst_n), 1);
      busy_n += int'(bus.busy);
      if (k < 2) first_pat[k] = bus.dut_in;
      bus.dut_out = resp[k];
      bus.start = hold || (k == mid_start);
      lf = step(lf, 16'h0);
    end
    @(negedge clk);
    check("flush_din", 32'(bus.dut_in), 0);
    check("flush_done", 32'(bus.done), 0);
    busy_n += int'(bus.busy);
    bus.dut_out = resp[P];
    bus.start = hold;
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 1);
    check("done_busy", 32'(bus.busy), 0);
    check("signature", 32'(bus.signature), 32'(sig));
    check("busy_len", 32'(busy_n), P + 3);
    bus.golden = gold;
    bus.dut_out = '0;
    @(negedge clk);
    check("done_clear", 32'(bus.done), 0);
    check("pass", 32'(bus.pass), 32'(exp_pass(sig, gold)));
    check("sig_held", 32'(bus.signature), 32'(sig));
    check("post_busy", 32'(bus.busy), 0);
    if (hold) begin
      @(negedge clk);
      check("retrigger", 32'(bus.busy), 1);
      bus.start = 1'b0;
      for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
      check("retrig_done", 32'(bus.done), 1);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.golden = '0;
    bus.dut_out = '0;
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_pass", 32'(bus.pass), 0);
    check("rst_sig", 32'(bus.signature), 0);
    check("rst_dut_rst_n", 32'(bus.dut_rst_n), 0);
    check("rst_din", 32'(bus.dut_in), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_rst_n", 32'(bus.dut_rst_n), 1);

    for (int i = 0; i <= P; i++) resp[i] = '0;
    run(16'h0000, -1, 1'b0);
    check("first_pat0", 32'(first_pat[0]), 32'h0CE1);
    check("first_pat1", 32'(first_pat[1]), 32'h09C3);
    check("zero_sig", 32'(bus.signature), 0);
    run(16'h0001, -1, 1'b0);

    resp[0] = 3'd1;
    run(16'h0000, -1, 1'b0);
    check("sig_0010", 32'(bus.signature), 32'h0010);

    for (int r = 0; r < 10; r++) begin
      logic [15:0] gx;
      int mid;
      for (int i = 0; i <= P; i++) resp[i] = OUT_W'($urandom);
      gx = ($urandom_range(0, 1) == 0) ? 16'h0 :
           16'($urandom_range(1, 65535));
      mid = int'($urandom_range(0, P)) - 1;
      run(gx, mid, 1'b0);
    end

    for (int i = 0; i <= P; i++) resp[i] = OUT_W'($urandom);
    run(16'h0000, -1, 1'b1);

    @(negedge clk);
    bus.start = 1'b1;
    bus.dut_out = 3'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(bus.busy), 1);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_pass", 32'(bus.pass), 0);
    check("abort_sig", 32'(bus.signature), 0);
    check("abort_rst_n", 32'(bus.dut_rst_n), 0);
    @(negedge clk);
    reset = 1'b1;
    bus.dut_out = '0;
    @(negedge clk);
    check("release_rst_n", 32'(bus.dut_rst_n), 1);
    check("release_busy", 32'(bus.busy), 0);

    for (int i = 0; i <= P; i++) resp[i] = OUT_W'($urandom);
    run(16'h0000, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bench_seq_bist.md
# bench_seq_bist

Built-in self-test harness for the generic sequential benchmark circuits used in the hardware-trojan experiments. It drives the benchmark's parallel input bus with LFSR pseudo-random patterns and compacts the benchmark's output into a MISR signature. It then compares that signature against a golden value. It sits between the experiment controller, which pulses `start` and reads `pass`/`signature`, and one benchmark instance, which receives `dut_in`/`dut_rst_n` and returns `dut_out`.

## Interface
- `IN_W`, 12: width of `dut_in`; 1..16.
- `OUT_W`, 1: width of `dut_out`; 1..16.
- `PATTERNS`, 256: number of patterns applied per run; 1..65535.
- `LFSR_SEED`, 16'hACE1: LFSR load value at each run start; a value of 0 is replaced by 16'hACE1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled in IDLE only.
- `golden`  in  16  expected signature; sampled in DONE.
- `dut_in`  out  IN_W  pattern bus to the benchmark: `lfsr[IN_W-1:0]`.
- `dut_rst_n`  out  1  active-low reset to the benchmark.
- `dut_out`  in  OUT_W  benchmark response.
- `busy`  out  1  high from DUT_RST through FLUSH.
- `done`  out  1  one-cycle pulse in DONE.
- `pass`  out  1  result of the signature compare; held until the next run starts.
- `signature`  out  16  MISR value; held after the run.

## Operation
- Reset values:
  - FSM in IDLE.
  - `dut_in` = 0, `dut_rst_n` = 0, `busy` = 0, `done` = 0, `pass` = 0, `signature` = 0.
  - LFSR = seed, MISR = 0.
- FSM states: IDLE → DUT_RST (2 cycles) → APPLY (PATTERNS cycles) → FLUSH (1 cycle) → DONE (1 cycle) → IDLE.
- IDLE:
  - `dut_rst_n` = 1, `dut_in` = 0.
  - When `start` = 1: load LFSR with the seed, clear MISR and `pass`, go to DUT_RST.
- DUT_RST: `dut_rst_n` = 0 and `dut_in` = 0 for exactly 2 cycles.
- APPLY:
  - `dut_rst_n` = 1 and `dut_in` = `lfsr[IN_W-1:0]`.
  - The LFSR advances every cycle.
  - The MISR samples `dut_out` every cycle.
  - A 16-bit pattern counter ends the state after PATTERNS cycles.
- FLUSH:
  - `dut_in` = 0.
  - The MISR takes one more sample, capturing the response to the last pattern through the benchmark's one-cycle register latency.
- DONE:
  - `done` = 1.
  - `pass` ← (MISR == `golden`).
  - `signature` is updated continuously from the MISR during the run and is final in DONE.
- LFSR: 16-bit Fibonacci.
  - fb = s[15]^s[13]^s[12]^s[10].
  - next = {s[14:0], fb}.
- MISR: same polynomial.
  - next = {m[14:0], fb} ^ zero-extended `dut_out`.
- `start` in any state other than IDLE is ignored. A `start` held high re-triggers only after DONE → IDLE.
- Reset asserted mid-run aborts immediately to the reset values, and the benchmark is held in reset via `dut_rst_n` = 0.

## Timing
- `start` sampled at edge N:
  - `busy` rises after edge N.
  - DUT_RST covers cycles N+1..N+2.
  - The first pattern appears after edge N+2.
- `busy` stays high for exactly PATTERNS+3 cycles.
- `done` is high for the single cycle that follows.
- The MISR takes PATTERNS+1 samples per run.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `BENCH_BIST_GOLDEN_CMP_EN` defined: the compare logic is built, and `pass` behaves as described above.
- Not defined: no compare logic is built, `golden` is ignored, and `pass` is tied to 0. Signature collection is unchanged; the controller compares off-chip.

## Test plan
- Reset mid-APPLY → same cycle: `busy`/`done`/`pass`/`signature` = 0 and `dut_rst_n` = 0. After release, the FSM is in IDLE and `dut_rst_n` = 1.
- PATTERNS=4, seed 16'hACE1, one-cycle `start` pulse:
  - `dut_rst_n` is low for 2 cycles.
  - `dut_in` = 12'hCE1, then 12'h9C3.
  - `busy` is high for 7 cycles, then `done` pulses once.
- PATTERNS=4, `dut_out` held at 0 → `signature` = 16'h0000. `golden` = 16'h0000 → `pass` = 1; `golden` = 16'h0001 → `pass` = 0 (macro defined).
- PATTERNS=4, `dut_out` = 1 only on the first APPLY sample → `signature` = 16'h0010.
- `start` pulsed during APPLY → ignored, and the run length is unchanged. `start` held high → a second run begins the cycle after DONE.
- Built without `BENCH_BIST_GOLDEN_CMP_EN`, `golden` equal to the signature → `pass` stays 0.
